// File: rtl/uart_apb_bridge.sv
// APB4 completer in front of the UART core: forwards 0x000-0x01C as single-cycle core
// strobes and hosts the sticky, maskable interrupt registers at 0x020 / 0x024.
module uart_apb_bridge #(
    parameter int ADDR_W   = 12,
    parameter int NUM_INTR = 8
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic [31:0]         pwdata_i,
    input  logic [3:0]          pstrb_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    output logic                core_pwrite_o,
    output logic                core_pread_o,
    output logic [ADDR_W-1:0]   core_paddr_o,
    output logic [31:0]         core_pwdata_o,
    input  logic [31:0]         core_prdata_i,
    input  logic [NUM_INTR-1:0] intr_i,
    output logic                irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CWR,
        S_CRD,
        S_CCAP,
        S_LOCAL,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_RX_DATA     = ADDR_W'(12'h008);
    localparam logic [ADDR_W-1:0] ADDR_CORE_LAST   = ADDR_W'(12'h01C);
    localparam logic [ADDR_W-1:0] ADDR_INTR_STATE  = ADDR_W'(12'h020);
    localparam logic [ADDR_W-1:0] ADDR_INTR_ENABLE = ADDR_W'(12'h024);
    localparam logic [ADDR_W-1:0] ADDR_PARK        = ADDR_W'(12'hFFC);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic                r_pready;
    logic                r_pslverr;
    logic                r_core_pwrite;
    logic                r_core_pread;
    logic [ADDR_W-1:0]   r_core_paddr;
    logic [31:0]         r_core_pwdata;
    logic [NUM_INTR-1:0] r_intr_prev;
    logic [NUM_INTR-1:0] r_intr_state;
    logic [NUM_INTR-1:0] r_intr_enable;
    logic                r_irq;

    logic                w_access;
    logic                w_err;
    logic                w_is_core;
    logic                w_local_wr;
    logic [NUM_INTR-1:0] w_intr_rise;
    logic [NUM_INTR-1:0] w_intr_clr;
    logic [31:0]         w_prdata;

    assign w_access   = psel_i & penable_i;
    assign w_err      = (paddr_i[1:0] != 2'b00) || (paddr_i > ADDR_INTR_ENABLE) ||
                        (pwrite_i && ((paddr_i == ADDR_RX_DATA) || (pstrb_i != 4'hF)));
    assign w_is_core  = (paddr_i <= ADDR_CORE_LAST);
    assign w_local_wr = (r_state == S_LOCAL) && r_write;

    assign w_intr_rise = intr_i & ~r_intr_prev;
    assign w_intr_clr  = (w_local_wr && (r_addr == ADDR_INTR_STATE)) ?
                         r_core_pwdata[NUM_INTR-1:0] : '0;

    // NOTE: every flop is assigned with <= so all registers sample the same pre-edge values.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_pready      <= 1'b0;
            r_pslverr     <= 1'b0;
            r_core_pwrite <= 1'b0;
            r_core_pread  <= 1'b0;
            r_core_paddr  <= ADDR_PARK;
            r_core_pwdata <= '0;
        end else begin
            // Strobes are single-cycle and the core address parks unless a strobe is issued.
            r_pready      <= 1'b0;
            r_pslverr     <= 1'b0;
            r_core_pwrite <= 1'b0;
            r_core_pread  <= 1'b0;
            r_core_paddr  <= ADDR_PARK;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr        <= paddr_i;
                        r_write       <= pwrite_i;
                        r_core_pwdata <= pwdata_i;
                        if (w_err) begin
                            r_state   <= S_ERR;
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                        end else if (w_is_core && pwrite_i) begin
                            r_state       <= S_CWR;
                            r_core_pwrite <= 1'b1;
                            r_core_paddr  <= paddr_i;
                            r_pready      <= 1'b1;
                        end else if (w_is_core) begin
                            r_state      <= S_CRD;
                            r_core_pread <= 1'b1;
                            r_core_paddr <= paddr_i;
                        end else begin
                            r_state  <= S_LOCAL;
                            r_pready <= 1'b1;
                        end
                    end
                end
                S_CRD: begin
                    r_state  <= S_CCAP;
                    r_pready <= 1'b1;
                end
                S_CWR, S_CCAP, S_LOCAL, S_ERR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lines already high at reset must not look like rising edges, hence prev = all ones.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_intr_prev   <= '1;
            r_intr_state  <= '0;
            r_intr_enable <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_intr_prev  <= intr_i;
            r_intr_state <= (r_intr_state & ~w_intr_clr) | w_intr_rise;
            if (w_local_wr && (r_addr == ADDR_INTR_ENABLE)) begin
                r_intr_enable <= r_core_pwdata[NUM_INTR-1:0];
            end
            r_irq <= |(r_intr_state & r_intr_enable);
        end
    end

    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_prdata = '0;
        if (r_state == S_CCAP) begin
            w_prdata = core_prdata_i;
        end else if ((r_state == S_LOCAL) && !r_write) begin
            w_prdata = (r_addr == ADDR_INTR_STATE) ? 32'(r_intr_state) : 32'(r_intr_enable);
        end
    end

    assign prdata_o      = w_prdata;
    assign pready_o      = r_pready;
    assign pslverr_o     = r_pslverr;
    assign core_pwrite_o = r_core_pwrite;
    assign core_pread_o  = r_core_pread;
    assign core_paddr_o  = r_core_paddr;
    assign core_pwdata_o = r_core_pwdata;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Self-checking bench for uart_apb_bridge: directed vector table, interrupt and reset
// sequences, and randomized APB traffic against a behavioural register/decode model.
module tb_uart_apb_bridge;

    logic        pclk = 1'b0;
    logic        prst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        core_pwrite;
    logic        core_pread;
    logic [11:0] core_paddr;
    logic [31:0] core_pwdata;
    logic [31:0] core_prdata;
    logic [7:0]  intr;
    logic        irq;

    always #5 pclk = ~pclk;

    uart_apb_bridge #(.ADDR_W(12), .NUM_INTR(8)) dut (
        .pclk_i       (pclk),
        .prst_i       (prst),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pstrb_i      (pstrb),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .core_pwrite_o(core_pwrite),
        .core_pread_o (core_pread),
        .core_paddr_o (core_paddr),
        .core_pwdata_o(core_pwdata),
        .core_prdata_i(core_prdata),
        .intr_i       (intr),
        .irq_o        (irq)
    );

    // Stand-in UART core: eight registers, read data registered one cycle after pread.
    logic [31:0] core_mem [8];
    int          bad_core_wr = 0;
    always @(posedge pclk) begin
        if (prst) begin
            for (int i = 0; i < 8; i++) core_mem[i] <= (i == 2) ? 32'hA5 : 32'h0;
            core_prdata <= '0;
        end else begin
            if (core_pwrite) begin
                core_mem[core_paddr[4:2]] <= core_pwdata;
                if (core_paddr > 12'h01C || core_paddr == 12'h008) bad_core_wr <= bad_core_wr + 1;
            end
            if (core_pread) core_prdata <= core_mem[core_paddr[4:2]];
        end
    end

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          exp_err;
        int          exp_rdy;
        int          exp_wr;
        int          exp_rd;
        int          chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          rdy_cyc;
        int          wr_cyc;
        int          rd_cyc;
        int          err;
        int          proto_ok;
        logic [31:0] rdata;
        logic [11:0] s_addr;
        logic [31:0] s_wdata;
    } xfer_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ref_mem [8];
    logic [7:0]  ref_state;
    logic [7:0]  ref_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_mem[i] = (i == 2) ? 32'hA5 : 32'h0;
        ref_state = '0;
        ref_en    = '0;
    endtask

    // Called just after a rising edge; returns just after the edge following pready.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output xfer_t res);
        res.rdy_cyc = 0; res.wr_cyc = 0; res.rd_cyc = 0; res.err = 0; res.proto_ok = 1;
        res.rdata = '0; res.s_addr = '0; res.s_wdata = '0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge pclk);
            if (core_pwrite) begin
                res.wr_cyc  = (res.wr_cyc == 0) ? i : 99;
                res.s_addr  = core_paddr;
                res.s_wdata = core_pwdata;
            end
            if (core_pread) begin
                res.rd_cyc = (res.rd_cyc == 0) ? i : 99;
                res.s_addr = core_paddr;
            end
            if (!core_pwrite && !core_pread && core_paddr != 12'hFFC) res.proto_ok = 0;
            if (!pready && (prdata != 32'h0 || pslverr)) res.proto_ok = 0;
            if (pready) begin
                res.rdy_cyc = i;
                res.rdata   = prdata;
                res.err     = pslverr ? 1 : 0;
                break;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic wr, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input int exp_err,
                             input int exp_rdy, input int exp_wr, input int exp_rd,
                             input int chk_rd, input logic [31:0] exp_rdata);
        xfer_t r;
        apb_xfer(wr, addr, data, strb, r);
        check({tag, " ready_cycle"}, r.rdy_cyc, exp_rdy);
        check({tag, " pslverr"}, r.err, exp_err);
        check({tag, " core_write_cycle"}, r.wr_cyc, exp_wr);
        check({tag, " core_read_cycle"}, r.rd_cyc, exp_rd);
        check({tag, " park_and_idle_outputs"}, r.proto_ok, 1);
        if (exp_wr != 0 || exp_rd != 0) check({tag, " core_paddr"}, 32'(r.s_addr), 32'(addr));
        if (exp_wr != 0) check({tag, " core_pwdata"}, r.s_wdata, data);
        if (chk_rd != 0) check({tag, " prdata"}, r.rdata, exp_rdata);
    endtask

    vec_t        vecs [17];
    logic [7:0]  nxt;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
    int          e_err, e_rdy, e_wr, e_rd, e_chk;
    logic [31:0] e_rdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'h000, 32'h0000_0010, 4'hF, 0, 2, 2, 0, 0, 32'h0};
        vecs[1]  = '{1'b1, 12'h01C, 32'hDEAD_BEEF, 4'hF, 0, 2, 2, 0, 0, 32'h0};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,         4'hF, 0, 3, 0, 2, 1, 32'h0000_00A5};
        vecs[3]  = '{1'b0, 12'h01C, 32'h0,         4'hF, 0, 3, 0, 2, 1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 12'h000, 32'h0,         4'hF, 0, 3, 0, 2, 1, 32'h0000_0010};
        vecs[5]  = '{1'b1, 12'h008, 32'h1234_5678, 4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[6]  = '{1'b1, 12'h002, 32'h1,         4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[7]  = '{1'b1, 12'h040, 32'h2,         4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[8]  = '{1'b1, 12'h004, 32'h3,         4'h1, 1, 2, 0, 0, 0, 32'h0};
        vecs[9]  = '{1'b0, 12'h026, 32'h0,         4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[10] = '{1'b0, 12'h028, 32'h0,         4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[11] = '{1'b0, 12'hFFC, 32'h0,         4'hF, 1, 2, 0, 0, 0, 32'h0};
        vecs[12] = '{1'b1, 12'h024, 32'hFFFF_FF5A, 4'hF, 0, 2, 0, 0, 0, 32'h0};
        vecs[13] = '{1'b0, 12'h024, 32'h0,         4'hF, 0, 2, 0, 0, 1, 32'h0000_005A};
        vecs[14] = '{1'b0, 12'h020, 32'h0,         4'hF, 0, 2, 0, 0, 1, 32'h0};
        vecs[15] = '{1'b1, 12'h024, 32'h0,         4'hF, 0, 2, 0, 0, 0, 32'h0};
        vecs[16] = '{1'b1, 12'h020, 32'hFF,        4'h7, 1, 2, 0, 0, 0, 32'h0};

        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; intr = '0;
        ref_reset();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset strobes/ready/err/irq", {27'b0, pready, pslverr, core_pwrite, core_pread, irq}, 32'h0);
        check("reset core_paddr", 32'(core_paddr), 32'h0000_0FFC);
        check("reset core_pwdata", core_pwdata, 32'h0);
        check("reset prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        prst = 1'b0;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 17; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                      vecs[i].exp_err, vecs[i].exp_rdy, vecs[i].exp_wr, vecs[i].exp_rd,
                      vecs[i].chk_rd, vecs[i].exp_rdata);
        end
        ref_mem[0] = 32'h0000_0010;
        ref_mem[7] = 32'hDEAD_BEEF;

        // Rising edge on rx line: state then irq, two cycles after the edge.
        run_check("en_wr", 1'b1, 12'h024, 32'h02, 4'hF, 0, 2, 0, 0, 0, 32'h0);
        intr = 8'h02;
        @(negedge pclk);
        @(negedge pclk);
        check("irq one cycle after edge", 32'(irq), 32'h0);
        @(negedge pclk);
        check("irq two cycles after edge", 32'(irq), 32'h1);
        @(posedge pclk); #1;
        run_check("state_rd", 1'b0, 12'h020, 32'h0, 4'hF, 0, 2, 0, 0, 1, 32'h02);
        run_check("w1c", 1'b1, 12'h020, 32'h02, 4'hF, 0, 2, 0, 0, 0, 32'h0);
        @(posedge pclk);
        @(negedge pclk);
        check("irq after w1c", 32'(irq), 32'h0);
        run_check("state_rd_cleared", 1'b0, 12'h020, 32'h0, 4'hF, 0, 2, 0, 0, 1, 32'h0);

        // Edge coinciding with the clearing write: set wins.
        intr = 8'h00;
        @(posedge pclk); #1;
        fork
            run_check("coinc_w1c", 1'b1, 12'h020, 32'h02, 4'hF, 0, 2, 0, 0, 0, 32'h0);
            begin
                @(posedge pclk);
                @(posedge pclk); #1;
                intr = 8'h02;
            end
        join
        run_check("coinc_state_rd", 1'b0, 12'h020, 32'h0, 4'hF, 0, 2, 0, 0, 1, 32'h02);
        @(negedge pclk);
        check("irq kept after coincident clear", 32'(irq), 32'h1);
        @(posedge pclk); #1;
        run_check("en_clear", 1'b1, 12'h024, 32'h0, 4'hF, 0, 2, 0, 0, 0, 32'h0);
        @(posedge pclk);
        @(negedge pclk);
        check("irq after enable cleared", 32'(irq), 32'h0);
        @(posedge pclk); #1;
        run_check("w1c_all", 1'b1, 12'h020, 32'hFF, 4'hF, 0, 2, 0, 0, 0, 32'h0);
        ref_state = '0;
        ref_en    = '0;

        // Randomized traffic and interrupt activity against the reference model.
        for (int n = 0; n < 200; n++) begin
            nxt = ($urandom_range(0, 2) == 0) ? 8'($urandom) : intr;
            ref_state = ref_state | (nxt & ~intr);
            intr = nxt;
            repeat (2) @(posedge pclk);
            @(negedge pclk);
            check("rnd irq", 32'(irq), 32'(|(ref_state & ref_en)));
            @(posedge pclk); #1;
            case ($urandom_range(0, 5))
                0, 1:    a = {7'b0, 3'($urandom_range(0, 7)), 2'b00};
                2:       a = 12'h020;
                3:       a = 12'h024;
                4:       a = 12'($urandom);
                default: a = 12'($urandom_range(0, 12'h027));
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            e_err = (a[1:0] != 2'b00 || a > 12'h024 || (w && (a == 12'h008 || s != 4'hF))) ? 1 : 0;
            e_rdy = 2; e_wr = 0; e_rd = 0; e_chk = 0; e_rdata = '0;
            if (e_err == 0 && a <= 12'h01C) begin
                if (w) begin
                    e_wr = 2;
                end else begin
                    e_rd = 2; e_rdy = 3; e_chk = 1; e_rdata = ref_mem[a[4:2]];
                end
            end else if (e_err == 0 && !w) begin
                e_chk = 1;
                e_rdata = (a == 12'h020) ? {24'b0, ref_state} : {24'b0, ref_en};
            end
            run_check($sformatf("rnd%0d", n), w, a, d, s, e_err, e_rdy, e_wr, e_rd, e_chk, e_rdata);
            if (e_err == 0 && w) begin
                if (a <= 12'h01C)      ref_mem[a[4:2]] = d;
                else if (a == 12'h024) ref_en = d[7:0];
                else                   ref_state = ref_state & ~d[7:0];
            end
        end

        // Line held high through reset must not register as an edge.
        prst = 1'b1;
        intr = 8'h80;
        repeat (3) @(posedge pclk);
        #1;
        prst = 1'b0;
        ref_reset();
        repeat (3) @(posedge pclk);
        #1;
        run_check("post_reset_state", 1'b0, 12'h020, 32'h0, 4'hF, 0, 2, 0, 0, 1, 32'h0);

        // Reset asserted while the read strobe is out.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("crd strobe before reset", 32'(core_pread), 32'h1);
        @(negedge pclk);
        check("after reset in crd: ready/read/err", {29'b0, pready, core_pread, pslverr}, 32'h0);
        check("after reset in crd: core_paddr", 32'(core_paddr), 32'h0000_0FFC);
        @(posedge pclk); #1;
        prst = 1'b0;
        ref_reset();
        run_check("restart_read", 1'b0, 12'h008, 32'h0, 4'hF, 0, 3, 0, 2, 1, 32'h0000_00A5);

        check("core writes to unmapped or read-only", bad_core_wr, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
